// File: rtl/pn_dsss_spreader.sv
// Spreads each double-buffered data bit over one PN period, starting on the epoch chip. The bits
// can be differentially encoded (PN_DIFF_ENC_EN). Chip outputs are registered 1 sysclk after chip_stb.
// data_ready is !nxt_full, and a bit accepted on the last chip of a bit continues the stream with no gap.
module pn_dsss_spreader #(
    parameter int CHIPS_PER_BIT = 1023,
    parameter int CNT_W         = 10
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       chip_stb,
    input  logic       pn_code,
    input  logic       pn_epoch,
    input  logic       data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       chip_out,
    output logic       chip_valid,
    output logic       bit_start,
    output logic       busy,
    output logic [7:0] underrun_cnt,
    output logic [7:0] epoch_err_cnt
);
    typedef enum logic [1:0] {IDLE, WAIT_EPOCH, SPREAD} state_t;

    localparam logic [CNT_W-1:0] LAST_CHIP = CNT_W'(CHIPS_PER_BIT - 1);

    state_t           state_q, state_d;
    logic             cur_q, cur_d, cur_full_q, cur_full_d;
    logic             nxt_q, nxt_d, nxt_full_q, nxt_full_d;
    logic [CNT_W-1:0] chip_cnt_q, chip_cnt_d;
    logic             chip_out_q, chip_out_d;
    logic             chip_valid_q, chip_valid_d;
    logic             bit_start_q, bit_start_d;
    logic [7:0]       underrun_cnt_q, underrun_cnt_d;
    logic [7:0]       epoch_err_cnt_q, epoch_err_cnt_d;
    logic             accept, release_bit, emit, tx_bit;
`ifdef PN_DIFF_ENC_EN
    logic             prev_tx_q, prev_tx_d;
`endif

    always_comb begin
        state_d         = state_q;
        cur_d           = cur_q;
        cur_full_d      = cur_full_q;
        nxt_d           = nxt_q;
        nxt_full_d      = nxt_full_q;
        chip_cnt_d      = chip_cnt_q;
        chip_out_d      = chip_out_q;
        chip_valid_d    = 1'b0;
        bit_start_d     = 1'b0;
        underrun_cnt_d  = underrun_cnt_q;
        epoch_err_cnt_d = epoch_err_cnt_q;
        accept          = data_valid && !nxt_full_q;
        release_bit     = 1'b0;
        emit            = 1'b0;
`ifdef PN_DIFF_ENC_EN
        tx_bit          = cur_q ^ prev_tx_q;
        prev_tx_d       = prev_tx_q;
`else
        tx_bit          = cur_q;
`endif

        case (state_q)
            IDLE: begin
                if (cur_full_q) state_d = WAIT_EPOCH;
            end
            WAIT_EPOCH: begin
                if (chip_stb && pn_epoch) begin
                    emit        = 1'b1;
                    bit_start_d = 1'b1;
                    chip_cnt_d  = CNT_W'(1);
                    state_d     = SPREAD;
                end
            end
            SPREAD: begin
                if (chip_stb) begin
                    emit = 1'b1;
                    if (pn_epoch && chip_cnt_q != '0) begin
                        // Epoch landed mid-bit: resynchronise by restarting the same bit.
                        if (epoch_err_cnt_q != 8'hFF) epoch_err_cnt_d = epoch_err_cnt_q + 8'd1;
                        bit_start_d = 1'b1;
                        chip_cnt_d  = CNT_W'(1);
                    end else begin
                        bit_start_d = (chip_cnt_q == '0);
                        if (chip_cnt_q == LAST_CHIP) begin
                            release_bit = 1'b1;
                            chip_cnt_d  = '0;
                            if (!nxt_full_q && !accept) begin
                                state_d = IDLE;
                                if (underrun_cnt_q != 8'hFF) underrun_cnt_d = underrun_cnt_q + 8'd1;
                            end
                        end else begin
                            chip_cnt_d = chip_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (emit) begin
            chip_valid_d = 1'b1;
            chip_out_d   = tx_bit ^ pn_code;
        end

        // An empty cur takes the incoming bit directly, so nxt only ever holds the waiting bit.
        if (release_bit) begin
`ifdef PN_DIFF_ENC_EN
            prev_tx_d = tx_bit;
`endif
            if (nxt_full_q) begin
                cur_d      = nxt_q;
                nxt_full_d = 1'b0;
            end else if (accept) begin
                cur_d = data_in;
            end else begin
                cur_full_d = 1'b0;
            end
        end else if (accept) begin
            if (!cur_full_q) begin
                cur_d      = data_in;
                cur_full_d = 1'b1;
            end else begin
                nxt_d      = data_in;
                nxt_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            cur_q           <= 1'b0;
            cur_full_q      <= 1'b0;
            nxt_q           <= 1'b0;
            nxt_full_q      <= 1'b0;
            chip_cnt_q      <= '0;
            chip_out_q      <= 1'b0;
            chip_valid_q    <= 1'b0;
            bit_start_q     <= 1'b0;
            underrun_cnt_q  <= 8'd0;
            epoch_err_cnt_q <= 8'd0;
`ifdef PN_DIFF_ENC_EN
            prev_tx_q       <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            cur_q           <= cur_d;
            cur_full_q      <= cur_full_d;
            nxt_q           <= nxt_d;
            nxt_full_q      <= nxt_full_d;
            chip_cnt_q      <= chip_cnt_d;
            chip_out_q      <= chip_out_d;
            chip_valid_q    <= chip_valid_d;
            bit_start_q     <= bit_start_d;
            underrun_cnt_q  <= underrun_cnt_d;
            epoch_err_cnt_q <= epoch_err_cnt_d;
`ifdef PN_DIFF_ENC_EN
            prev_tx_q       <= prev_tx_d;
`endif
        end
    end

    assign data_ready    = !nxt_full_q;
    assign chip_out      = chip_out_q;
    assign chip_valid    = chip_valid_q;
    assign bit_start     = bit_start_q;
    assign busy          = (state_q != IDLE);
    assign underrun_cnt  = underrun_cnt_q;
    assign epoch_err_cnt = epoch_err_cnt_q;
endmodule

// File: tb/tb_pn_dsss_spreader.sv
// Bench for pn_dsss_spreader: a random periodic PN source, a ready/valid data source and a
// scoreboard of transmitted bits that expects every bit as one epoch-aligned PN period of chips.
module tb_pn_dsss_spreader;
    localparam int CPB = 1023;

    logic       sysclk = 1'b0;
    logic       reset = 1'b0;
    logic       chip_stb = 1'b0;
    logic       pn_code = 1'b0;
    logic       pn_epoch = 1'b0;
    logic       data_in = 1'b0;
    logic       data_valid = 1'b0;
    logic       data_ready, chip_out, chip_valid, bit_start, busy;
    logic [7:0] underrun_cnt, epoch_err_cnt;

    pn_dsss_spreader #(.CHIPS_PER_BIT(CPB), .CNT_W(10)) dut (
        .sysclk(sysclk), .reset(reset), .chip_stb(chip_stb), .pn_code(pn_code),
        .pn_epoch(pn_epoch), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .chip_out(chip_out), .chip_valid(chip_valid),
        .bit_start(bit_start), .busy(busy), .underrun_cnt(underrun_cnt),
        .epoch_err_cnt(epoch_err_cnt)
    );

    always #5 sysclk = ~sysclk;

    int checks = 0;
    int errors = 0;

    bit pn_seq[CPB];
    int phase = 0;
    int stb_gap_max = 1;
    int stb_wait = 0;
    bit slip_req = 1'b0;
    bit strobes_on = 1'b0;
    int valid_pct = 100;

    bit src_q[$];
    bit exp_q[$];
    bit prev_model = 1'b0;
    bit acc_pending = 1'b0;
    int accepts = 0;
    bit last_stb = 1'b0, last_code = 1'b0, last_epoch = 1'b0;
    bit have_bit = 1'b0;
    bit cur_tx = 1'b0;
    int cnt = 0;
    int exp_underrun = 0;
    int exp_err = 0;
    int bits_done = 0;
    int bits_owed = 0;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Each accepted data bit becomes one transmitted bit, differentially encoded if enabled.
    task automatic push_model(input bit d);
        bit tx;
`ifdef PN_DIFF_ENC_EN
        tx = d ^ prev_model;
        prev_model = tx;
`else
        tx = d;
`endif
        exp_q.push_back(tx);
        accepts++;
        bits_owed++;
    endtask

    // Stimulus drivers: capture what the DUT samples at this edge, then drive the next cycle.
    always @(posedge sysclk) begin
        last_stb = chip_stb;
        last_code = pn_code;
        last_epoch = pn_epoch;
        #1;
        if (strobes_on && stb_wait == 0) begin
            if (slip_req) begin
                phase = 0;
                slip_req = 1'b0;
            end
            chip_stb = 1'b1;
            pn_code = pn_seq[phase];
            pn_epoch = (phase == 0);
            phase = (phase + 1) % CPB;
            stb_wait = $urandom_range(stb_gap_max - 1, 0);
        end else begin
            chip_stb = 1'b0;
            pn_code = 1'($urandom);
            pn_epoch = 1'($urandom);
            if (stb_wait > 0) stb_wait--;
        end
        if (acc_pending) begin
            void'(src_q.pop_front());
            acc_pending = 1'b0;
            data_valid = 1'b0;
        end
        if (!data_valid) begin
            if (src_q.size() > 0 && $urandom_range(99, 0) < valid_pct) begin
                data_valid = 1'b1;
                data_in = src_q[0];
            end else begin
                data_in = 1'($urandom);
            end
        end
    end

    // Monitor then handshake capture, in one process so their order is fixed.
    always @(negedge sysclk) begin
        if (chip_valid) begin
            if (!have_bit || cnt == CPB) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_chip: chip_valid=1 required 0 (t=%0t)", $time);
                    have_bit = 1'b0;
                end else begin
                    cur_tx = exp_q.pop_front();
                    have_bit = 1'b1;
                    cnt = 0;
                    check("first_chip_on_epoch", int'(last_epoch), 1);
                end
            end else if (last_epoch) begin
                cnt = 0;
                exp_err++;
            end
            if (have_bit) begin
                check("chip_latency", int'(last_stb), 1);
                check("chip_out", int'(chip_out), int'(cur_tx ^ last_code));
                check("bit_start", int'(bit_start), int'(last_epoch));
                cnt++;
                if (cnt == CPB) begin
                    bits_done++;
                    bits_owed--;
                    if (exp_q.size() == 0) exp_underrun++;
                end
            end
        end else if (have_bit && last_stb && cnt > 0 && cnt < CPB) begin
            checks++;
            errors++;
            $display("FAIL missing_chip: chip_valid=0 required 1 at chip %0d (t=%0t)", cnt, $time);
        end
        acc_pending = data_valid && data_ready && reset;
        if (acc_pending) push_model(data_in);
    end

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge sysclk);
            #1;
            n++;
        end while (!(src_q.size() == 0 && exp_q.size() == 0 && !busy && (!have_bit || cnt == CPB))
                   && n < budget);
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: waited %0d cycles required completion", name, n);
        end
    endtask

    task automatic wait_chip(input int target, input int budget);
        int n = 0;
        while (!(have_bit && cnt == target) && n < budget) begin
            @(negedge sysclk);
            #1;
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_chip_timeout: chip %0d not reached in %0d cycles", target, n);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data_ready"}, int'(data_ready), 1);
        check({tag, "_chip_out"}, int'(chip_out), 0);
        check({tag, "_chip_valid"}, int'(chip_valid), 0);
        check({tag, "_bit_start"}, int'(bit_start), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_underrun_cnt"}, int'(underrun_cnt), 0);
        check({tag, "_epoch_err_cnt"}, int'(epoch_err_cnt), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ur0;
        for (int i = 0; i < CPB; i++) pn_seq[i] = 1'($urandom);
        pn_seq[0] = 1'b1;
        pn_seq[1] = 1'b0;
        repeat (3) @(posedge sysclk);
        #2;
        check_reset_values("reset");
        @(negedge sysclk);
        reset = 1'b1;

        // Single bit: epoch falls on the 5th strobe after the bit is offered.
        phase = CPB - 4;
        src_q.push_back(1'b1);
        strobes_on = 1'b1;
        wait_done("single", 3000);
        check("single_busy", int'(busy), 0);
        check("single_underrun", int'(underrun_cnt), 1);
        check("single_underrun_model", int'(underrun_cnt), exp_underrun);
        check("single_bits_done", bits_done, 1);

        // Back-to-back with data_valid held: ready drops after two accepts.
        ur0 = exp_underrun;
        accepts = 0;
        src_q.push_back(1'b1);
        src_q.push_back(1'b0);
        src_q.push_back(1'b1);
        for (int n = 0; n < 50 && accepts < 2; n++) @(negedge sysclk);
        @(posedge sysclk);
        #1;
        check("bp_ready_low", int'(data_ready), 0);
        check("bp_accepts", accepts, 2);
        wait_chip(600, 3000);
        check("bp_one_accept_per_bit", accepts, 2);
        wait_done("b2b", 6000);
        check("b2b_accepts", accepts, 3);
        check("b2b_underrun_delta", int'(underrun_cnt) - 1, ur0);
        check("b2b_underrun_model", int'(underrun_cnt), exp_underrun);
        check("b2b_bits_done", bits_done, 4);

        // Misaligned epoch: the PN source slips back to chip 0 mid-bit.
        src_q.push_back(1'($urandom));
        wait_chip(500, 3000);
        slip_req = 1'b1;
        wait_done("slip", 4000);
        check("slip_epoch_err", int'(epoch_err_cnt), 1);
        check("slip_epoch_err_model", int'(epoch_err_cnt), exp_err);
        check("slip_bits_done", bits_done, 5);

        // Reset mid-bit: partial bit discarded, outputs return to reset values at once.
        src_q.push_back(1'b1);
        wait_chip(300, 3000);
        reset = 1'b0;
        exp_q.delete();
        src_q.delete();
        have_bit = 1'b0;
        bits_owed = 0;
        acc_pending = 1'b0;
        data_valid = 1'b0;
        prev_model = 1'b0;
        exp_underrun = 0;
        exp_err = 0;
        #1;
        check_reset_values("midreset");
        repeat (20) @(posedge sysclk);
        @(negedge sysclk);
        reset = 1'b1;
        repeat (1100) @(negedge sysclk);
        check("midreset_idle_busy", int'(busy), 0);
        src_q.push_back(1'b0);
        wait_done("after_reset", 3000);
        check("after_reset_underrun", int'(underrun_cnt), 1);
        check("after_reset_bits_done", bits_done, 6);

        // Random phase: irregular strobes, sporadic data_valid, batches separated by idle gaps.
        stb_gap_max = 3;
        valid_pct = 30;
        src_q.push_back(1'b1);
        src_q.push_back(1'b1);
        src_q.push_back(1'b0);
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 2; k++) src_q.push_back(1'($urandom));
            wait_done("random", 30000);
            repeat ($urandom_range(50, 1)) @(negedge sysclk);
        end
        check("random_underrun_model", int'(underrun_cnt), exp_underrun);
        check("random_epoch_err_model", int'(epoch_err_cnt), exp_err);
        check("random_epoch_err", int'(epoch_err_cnt), 0);
        check("random_bits_owed", bits_owed, 0);
        check("random_bits_done", bits_done, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
